// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the next-PC predictor: predictor modes, 2-bit direction
// counter states and a small elaboration-time helper.
package branch_predictor_pkg;

  localparam int PRED_MODE_NT        = 0;
  localparam int PRED_MODE_BIMODAL   = 1;
  localparam int PRED_MODE_GSHARE    = 2;
  localparam int PRED_MODE_BTB_TAKEN = 3;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter; forcing to
// strongly-taken wins over allocation init, which wins over inc/dec.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  input  logic       dec,
  input  logic       force_st,
  input  logic       init_wt,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (force_st) begin
      cnt_next = CNT_ST;
    end else if (init_wt) begin
      cnt_next = CNT_WT;
    end else if (inc && (cnt != CNT_ST)) begin
      cnt_next = cnt + 2'd1;
    end else if (dec && (cnt != CNT_SNT)) begin
      cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit direction counters (bimodal or gshare) giving
// IF a same-cycle next-PC guess; trained at branch resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ENTRIES   = 16,
  parameter int MODE      = 1,
  parameter int HIST_BITS = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic                 pred_hit,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic                 update_is_cond,
  input  logic                 update_taken,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_pred_taken,
  input  logic [WORD_SIZE-1:0] update_pred_target,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int TAG_W = WORD_SIZE - IDX;

  generate
    if (!is_pow2(ENTRIES) || (ENTRIES < 2) || (ENTRIES > 256)) begin : g_bad_entries
      $error("branch_predictor: ENTRIES must be a power of two in 2..256");
    end
    if ((HIST_BITS < 1) || (HIST_BITS > IDX)) begin : g_bad_hist
      $error("branch_predictor: HIST_BITS must be in 1..log2(ENTRIES)");
    end
    if ((MODE < PRED_MODE_NT) || (MODE > PRED_MODE_BTB_TAKEN)) begin : g_bad_mode
      $error("branch_predictor: MODE must be 0..3");
    end
  endgenerate

  logic                 valid_reg  [ENTRIES];
  logic [TAG_W-1:0]     tag_reg    [ENTRIES];
  logic [WORD_SIZE-1:0] target_reg [ENTRIES];
  logic [1:0]           cnt_reg    [ENTRIES];
  logic [HIST_BITS-1:0] ghr_reg;
  logic [HIST_BITS-1:0] ghr_next;
  logic [CNT_WIDTH-1:0] mp_count_reg;

  logic [IDX-1:0]   hist_mask;
  logic [IDX-1:0]   lk_idx;
  logic [IDX-1:0]   lk_cidx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  logic [IDX-1:0]   up_idx;
  logic [IDX-1:0]   up_cidx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_alloc;
  logic             up_we;
  logic             btb_we;
  logic [1:0]       cnt_next;

  // History only steers the counter index in gshare mode.
  assign hist_mask = (MODE == PRED_MODE_GSHARE) ? IDX'(ghr_reg) : '0;

  // ---------------- lookup (combinational, pre-update state) ----------------
  assign lk_idx  = lookup_pc[IDX-1:0];
  assign lk_tag  = lookup_pc[WORD_SIZE-1:IDX];
  assign lk_cidx = lk_idx ^ hist_mask;
  assign lk_hit  = reset_n && valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);

  always_comb begin
    lk_taken = 1'b0;
    if (MODE == PRED_MODE_NT) begin
      lk_taken = 1'b0;
    end else if ((MODE == PRED_MODE_BIMODAL) || (MODE == PRED_MODE_GSHARE)) begin
      lk_taken = lk_hit && cnt_reg[lk_cidx][1];
    end else begin
      lk_taken = lk_hit;
    end
  end

  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_taken;
  assign pred_target = lk_taken ? target_reg[lk_idx] : (lookup_pc + WORD_SIZE'(1));

  // ---------------- update path ----------------
  assign up_idx   = update_pc[IDX-1:0];
  assign up_tag   = update_pc[WORD_SIZE-1:IDX];
  assign up_cidx  = up_idx ^ hist_mask;
  assign up_hit   = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
  assign up_alloc = update_taken && !up_hit;
  assign up_we    = reset_n && update_valid;
  assign btb_we   = up_we && update_taken;

  assign mispredict = up_we &&
                      ((update_taken != update_pred_taken) ||
                       (update_taken && (update_target != update_pred_target)));

  bp_sat_counter u_sat_counter (
    .cnt      (cnt_reg[up_cidx]),
    .inc      (update_is_cond && update_taken),
    .dec      (update_is_cond && !update_taken),
    .force_st (!update_is_cond),
    .init_wt  (up_alloc),
    .cnt_next (cnt_next)
  );

  generate
    if (HIST_BITS == 1) begin : g_ghr_1
      assign ghr_next = update_taken;
    end else begin : g_ghr_n
      assign ghr_next = {ghr_reg[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        cnt_reg[i]   <= CNT_WNT;
      end
      ghr_reg      <= '0;
      mp_count_reg <= '0;
    end else if (update_valid) begin
      if (update_taken) begin
        valid_reg[up_idx] <= 1'b1;
      end
      cnt_reg[up_cidx] <= cnt_next;
      if ((MODE == PRED_MODE_GSHARE) && update_is_cond) begin
        ghr_reg <= ghr_next;
      end
      if (mispredict && (mp_count_reg != '1)) begin
        mp_count_reg <= mp_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Tags and targets are qualified by valid_reg, so they carry no reset.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_reg[up_idx]    <= up_tag;
      target_reg[up_idx] <= update_target;
    end
  end

  assign mispredict_count = mp_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a bimodal and a gshare predictor share stimulus and are checked
// against a table-level reference model computed from the predictor rules.
module tb_branch_predictor;

  localparam int E = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] lookup_pc = '0;
  logic        update_valid = 1'b0;
  logic [15:0] update_pc = '0;
  logic        update_is_cond = 1'b0;
  logic        update_taken = 1'b0;
  logic [15:0] update_target = '0;
  logic        upd_pred_taken_a = 1'b0, upd_pred_taken_b = 1'b0;
  logic [15:0] upd_pred_target_a = '0, upd_pred_target_b = '0;

  logic        pred_taken_a, pred_hit_a, mispredict_a;
  logic [15:0] pred_target_a, mispredict_count_a;
  logic        pred_taken_b, pred_hit_b, mispredict_b;
  logic [15:0] pred_target_b;
  logic [3:0]  mispredict_count_b;

  always #5 clk = ~clk;

  branch_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(1), .HIST_BITS(4), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken_a), .pred_target(pred_target_a), .pred_hit(pred_hit_a),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
    .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(upd_pred_taken_a), .update_pred_target(upd_pred_target_a),
    .mispredict(mispredict_a), .mispredict_count(mispredict_count_a)
  );

  branch_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(2), .HIST_BITS(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken_b), .pred_target(pred_target_b), .pred_hit(pred_hit_b),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
    .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(upd_pred_taken_b), .update_pred_target(upd_pred_target_b),
    .mispredict(mispredict_b), .mispredict_count(mispredict_count_b)
  );

  // ---------------- reference model ----------------
  int m_mode [2] = '{1, 2};
  int m_cmax [2] = '{65535, 15};
  bit m_valid [2][E];
  int m_tag   [2][E];
  int m_tgt   [2][E];
  int m_cnt   [2][E];
  int m_ghr   [2];
  int m_count [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < E; i++) begin
        m_valid[d][i] = 1'b0;
        m_cnt[d][i]   = 1;
      end
      m_ghr[d]   = 0;
      m_count[d] = 0;
    end
  endfunction

  function automatic void predict(input int d, input int pc, output bit hit, output bit tk, output int tg);
    int i  = pc % E;
    int ci = (m_mode[d] == 2) ? (i ^ m_ghr[d]) : i;
    hit = m_valid[d][i] && (m_tag[d][i] == pc / E);
    case (m_mode[d])
      0:       tk = 1'b0;
      3:       tk = hit;
      default: tk = hit && (m_cnt[d][ci] >= 2);
    endcase
    tg = tk ? m_tgt[d][i] : (pc + 1) % 65536;
  endfunction

  function automatic void apply_update(input int d, input int pc, input bit cond, input bit tk,
                                       input int tgt, input bit mp);
    int  i     = pc % E;
    int  ci    = (m_mode[d] == 2) ? (i ^ m_ghr[d]) : i;
    bit  hit   = m_valid[d][i] && (m_tag[d][i] == pc / E);
    bit  alloc = tk && !hit;
    if (tk) begin
      m_valid[d][i] = 1'b1;
      m_tag[d][i]   = pc / E;
      m_tgt[d][i]   = tgt;
    end
    if (!cond)      m_cnt[d][ci] = 3;
    else if (alloc) m_cnt[d][ci] = 2;
    else if (tk)    m_cnt[d][ci] = (m_cnt[d][ci] == 3) ? 3 : m_cnt[d][ci] + 1;
    else            m_cnt[d][ci] = (m_cnt[d][ci] == 0) ? 0 : m_cnt[d][ci] - 1;
    if (m_mode[d] == 2 && cond) m_ghr[d] = ((m_ghr[d] * 2) + int'(tk)) % 16;
    if (mp && m_count[d] < m_cmax[d]) m_count[d]++;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string nm;
    int    lpc;
    bit    hit_a, tk_a, mp_a, hit_b, tk_b, mp_b;
    int    tg_a, cnt_a, tg_b, cnt_b;
  } exp_t;

  exp_t sb_q [$];
  int   total = 0;
  int   bad = 0;
  int   txn = 0;

  function automatic void chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.nm, "/hit_a"}, int'(pred_hit_a), int'(e.hit_a));
        chk({e.nm, "/taken_a"}, int'(pred_taken_a), int'(e.tk_a));
        chk({e.nm, "/target_a"}, int'(pred_target_a), e.tg_a);
        chk({e.nm, "/mp_a"}, int'(mispredict_a), int'(e.mp_a));
        chk({e.nm, "/count_a"}, int'(mispredict_count_a), e.cnt_a);
        chk({e.nm, "/hit_b"}, int'(pred_hit_b), int'(e.hit_b));
        chk({e.nm, "/taken_b"}, int'(pred_taken_b), int'(e.tk_b));
        chk({e.nm, "/target_b"}, int'(pred_target_b), e.tg_b);
        chk({e.nm, "/mp_b"}, int'(mispredict_b), int'(e.mp_b));
        chk({e.nm, "/count_b"}, int'(mispredict_count_b), e.cnt_b);
        $display("txn %0d %s lpc=%04h a:hit=%0d tk=%0d tgt=%04h mp=%0d cnt=%0d b:hit=%0d tk=%0d tgt=%04h mp=%0d cnt=%0d",
                 txn, e.nm, e.lpc, pred_hit_a, pred_taken_a, pred_target_a, mispredict_a,
                 mispredict_count_a, pred_hit_b, pred_taken_b, pred_target_b, mispredict_b,
                 mispredict_count_b);
        txn++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input string nm, input int lpc, input bit uv, input int upc,
                      input bit cond, input bit tk, input int tgt, input bit rst);
    exp_t e;
    bit   h, t, ph, pt, mp;
    int   g, pg;
    @(negedge clk);
    if (!rst) model_reset();
    reset_n        = rst;
    lookup_pc      = 16'(lpc);
    update_valid   = uv;
    update_pc      = 16'(upc);
    update_is_cond = cond;
    update_taken   = tk;
    update_target  = 16'(tgt);
    e.nm  = nm;
    e.lpc = lpc;
    for (int d = 0; d < 2; d++) begin
      predict(d, lpc, h, t, g);
      predict(d, upc, ph, pt, pg);
      mp = rst && uv && ((tk != pt) || (tk && (tgt != pg)));
      if (d == 0) begin
        e.hit_a = h; e.tk_a = t; e.tg_a = g; e.mp_a = mp; e.cnt_a = m_count[0];
        upd_pred_taken_a = pt; upd_pred_target_a = 16'(pg);
      end else begin
        e.hit_b = h; e.tk_b = t; e.tg_b = g; e.mp_b = mp; e.cnt_b = m_count[1];
        upd_pred_taken_b = pt; upd_pred_target_b = 16'(pg);
      end
    end
    sb_q.push_back(e);
    if (rst && uv) begin
      apply_update(0, upc, cond, tk, tgt, e.mp_a);
      apply_update(1, upc, cond, tk, tgt, e.mp_b);
    end
  endtask

  initial begin : driver
    int pc, lpc, tgt;
    bit cond, tk, rst;
    model_reset();

    step("reset", 16'h0010, 0, 0, 0, 0, 0, 0);
    step("reset_upd_discard", 16'h0010, 1, 16'h0020, 1, 1, 16'h0005, 0);
    step("wrap_lookup", 16'hFFFF, 0, 0, 0, 0, 0, 1);

    step("alloc_0020", 16'h0020, 1, 16'h0020, 1, 1, 16'h0005, 1);
    step("alloc_look", 16'h0020, 0, 0, 0, 0, 0, 1);

    step("nt1", 16'h0020, 1, 16'h0020, 1, 0, 0, 1);
    step("nt2", 16'h0020, 1, 16'h0020, 1, 0, 0, 1);
    step("nt_look", 16'h0020, 0, 0, 0, 0, 0, 1);
    step("nt3", 16'h0020, 1, 16'h0020, 1, 0, 0, 1);
    step("nt3_look", 16'h0020, 0, 0, 0, 0, 0, 1);

    step("alias_alloc_same_cycle", 16'h0003, 1, 16'h0003, 1, 1, 16'h0100, 1);
    step("alias_look", 16'h0013, 0, 0, 0, 0, 0, 1);
    step("alias_hit", 16'h0003, 0, 0, 0, 0, 0, 1);

    step("jpr1", 16'h0040, 1, 16'h0040, 0, 1, 16'h0200, 1);
    step("jpr2", 16'h0040, 1, 16'h0040, 0, 1, 16'h0300, 1);
    step("jpr_look", 16'h0040, 0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 16; k++) begin
      step("gshare_alt", 16'h0008, 1, 16'h0008, 1, (k % 2) == 0, 16'h0050, 1);
      if (k >= 8) begin
        #3;
        chk("gshare_last8_mp", int'(mispredict_b), 0);
      end
    end

    step("rst_mid", 16'h0040, 1, 16'h0040, 0, 1, 16'h0400, 0);
    step("rst_hold", 16'h0020, 1, 16'h0020, 1, 1, 16'h0400, 0);
    step("rst_look", 16'h0040, 0, 0, 0, 0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      pc   = ($urandom_range(0, 3) * 16) + $urandom_range(0, 15);
      lpc  = ($urandom_range(0, 7) == 0) ? pc : ($urandom_range(0, 3) * 16) + $urandom_range(0, 15);
      tgt  = (pc + 16 * $urandom_range(1, 2)) % 65536;
      cond = $urandom_range(0, 3) != 0;
      tk   = cond ? bit'($urandom_range(0, 1)) : 1'b1;
      rst  = $urandom_range(0, 99) != 0;
      step("random", lpc, bit'($urandom_range(0, 4) != 0), pc, cond, tk, tgt, rst);
    end

    repeat (4) @(negedge clk);
    #4;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch predictor for the 16-bit pipelined CPU.
- Gives the IF stage a same-cycle next-PC guess, replacing the current fixed "pc + 1 unless flushed" rule.
- Is trained from the branch-resolution stage using a direct-mapped BTB, 2-bit saturating direction counters and an optional global history (gshare).
- Keeps a saturating mispredict counter for performance reporting alongside num_inst.

Parameters:
WORD_SIZE, 16, PC/target width (matches `WORD_SIZE)
ENTRIES, 16, BTB/counter table depth; power of two, 2..256; anything else is an elaboration error
MODE, 1, 0 = always not-taken, 1 = bimodal, 2 = gshare, 3 = always-taken-on-BTB-hit
HIST_BITS, 4, global history length for MODE 2; must be <= log2(ENTRIES)
CNT_WIDTH, 16, mispredict_count width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
lookup_pc  input  WORD_SIZE  PC being fetched (IF address1)
pred_taken  output  1  predicted redirect
pred_target  output  WORD_SIZE  predicted next PC
pred_hit  output  1  BTB tag match for lookup_pc
update_valid  input  1  a resolved control instruction this cycle
update_pc  input  WORD_SIZE  PC of the resolved instruction
update_is_cond  input  1  1 = conditional branch (BNE/BEQ/BGZ/BLZ); 0 = JMP/JAL/JPR/JRL
update_taken  input  1  actual outcome
update_target  input  WORD_SIZE  actual taken target
update_pred_taken  input  1  prediction carried down the pipe for this instruction
update_pred_target  input  WORD_SIZE  predicted target carried down the pipe
mispredict  output  1  combinational: update_valid and (taken mismatch, or taken with target mismatch)
mispredict_count  output  CNT_WIDTH  saturating count of mispredicts

Behaviour:
Addressing:
- IDX = log2(ENTRIES); index = pc[IDX-1:0]; tag = pc[WORD_SIZE-1:IDX].
- Counter index: MODE 2 uses index XOR {zeros, ghr}; all other modes use index.

Lookup (combinational, 0-cycle latency):
- pred_hit = valid[index] && tag match.
- pred_taken:
  - MODE 0: 0.
  - MODE 1/2: pred_hit && cnt[1].
  - MODE 3: pred_hit.
- pred_target = btb_target[index] if pred_taken, else lookup_pc + 1 (wraps modulo 2^WORD_SIZE).
- pred_target never carries X, including after reset.

Update (at posedge clk when update_valid = 1):
- BTB allocation:
  - If update_taken and the BTB misses on update_pc, write valid = 1, tag and target.
  - A not-taken miss does not allocate.
  - A hit with update_taken rewrites the target (JPR/JRL targets change).
- Direction counter:
  - Conditional branch: saturating +1 if taken, -1 if not; stays at 2'b11 / 2'b00 at the limits.
  - New allocation: counter initialised to 2'b10.
  - Unconditional jump: counter forced to 2'b11.
- ghr (MODE 2, conditional branches only): ghr <= {ghr[HIST_BITS-2:0], update_taken}.
  - Non-speculative; updated only at resolve.
- Mispredict counter:
  - mispredict_count increments by 1 when mispredict = 1; it holds at all-ones.
- MODE 0 still maintains the BTB and the mispredict count.

Simultaneous events:
- Lookup and update to the same index in one cycle: lookup returns pre-update state (no bypass).
- The new state is visible on the next cycle.

Reset (asynchronous, reset_n = 0):
- All valid = 0, all counters = 2'b01, ghr = 0, mispredict_count = 0.
- Outputs while in reset: pred_taken = 0, pred_hit = 0, pred_target = lookup_pc + 1, mispredict = 0 (gated by reset).
- An update coincident with the reset edge is discarded.
- Table targets and tags need not be reset, but they must be masked by valid.

Inputs while update_valid = 0 are ignored.

Decomposition:
Shared header (alongside the opcode defines):
- PRED_MODE_NT/BIMODAL/GSHARE/BTB_TAKEN encodings.
- Counter encodings CNT_SNT = 2'b00, CNT_WNT = 2'b01, CNT_WT = 2'b10, CNT_ST = 2'b11.

Sub-module bp_sat_counter:
- 2-bit next-state function (inc, dec, force_st, init_wt).
- Instantiated once on the update path.

The tables (valid, tag, target, counter arrays) stay in branch_predictor.

Test Plan:
1. Reset, lookup_pc = 16'h0010 -> pred_hit = 0, pred_taken = 0, pred_target = 16'h0011, mispredict_count = 0.
2. MODE 1: one update pc = 0x0020, cond, taken, target = 0x0005, pred_taken = 0 -> mispredict = 1, count = 1; next cycle lookup 0x0020 gives hit = 1, taken = 1 (cnt 2'b10), target = 0x0005.
3. Same branch, then two not-taken updates -> counter goes 10 -> 01 -> 00; lookup gives taken = 0, target = 0x0021; a third not-taken stays 00.
4. Aliasing, ENTRIES = 16: allocate 0x0003 (taken, target 0x0100), then lookup 0x0013 -> hit = 0 (tag mismatch), target = 0x0014.
5. JPR at 0x0040 resolves to 0x0200 then 0x0300 -> the second update rewrites the target; lookup gives 0x0300, counter 2'b11.
6. MODE 2, HIST_BITS = 4: alternating T/N outcomes at 0x0008 for 16 updates -> mispredicts in the last 8 updates are 0.
7. Assert reset_n mid-stream with a valid update in flight -> tables invalidated immediately and the count returns to 0.
